codma_chain_checker: RTL and testbench

- Synthesizable self-checking engine for codma regression and on-chip BIST.
- Walks a codma task descriptor chain held in a golden (pre-transfer) memory snapshot. For each task, compares source words in the golden image against destination words in the DUT memory.
- Reports mismatch count, first failing address, bytes checked and an error code.
- Generalises in word width, memory depth and link-chain length. Adds range, granularity, type and chain-depth checking.

---
 rtl/codma_chain_checker_if.sv | 27 ++
 rtl/codma_chain_checker.sv | 209 ++++++++++++++++++++
 tb/tb_codma_chain_checker.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/codma_chain_checker_if.sv
// rtl/codma_chain_checker_if.sv - golden and DUT memory read bus bundle for codma_chain_checker
interface codma_chain_checker_if #(
   parameter int MEM_DEPTH = 32,
   parameter int MEM_WIDTH = 8
);
   localparam int AW = $clog2(MEM_DEPTH);
   localparam int DW = 8 * MEM_WIDTH;

   logic          ref_rd_en_o;
   logic [AW-1:0] ref_rd_addr_o;
   logic [DW-1:0] ref_rd_data_i;
   logic          dut_rd_en_o;
   logic [AW-1:0] dut_rd_addr_o;
   logic [DW-1:0] dut_rd_data_i;

   // checker side: issues strobes and addresses, receives data one cycle later
   modport master (
      output ref_rd_en_o, ref_rd_addr_o, dut_rd_en_o, dut_rd_addr_o,
      input  ref_rd_data_i, dut_rd_data_i
   );

   // memory side: answers strobes with registered read data
   modport slave (
      input  ref_rd_en_o, ref_rd_addr_o, dut_rd_en_o, dut_rd_addr_o,
      output ref_rd_data_i, dut_rd_data_i
   );
endinterface

// File: rtl/codma_chain_checker.sv
// rtl/codma_chain_checker.sv - codma descriptor chain walker and data compare engine (optional CODMA_CHK_STATUS_EN)
module codma_chain_checker #(
   parameter int MEM_DEPTH = 32,
   parameter int MEM_WIDTH = 8,
   parameter int MAX_LINKS = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [31:0]      task_ptr_i,
`ifdef CODMA_CHK_STATUS_EN
   input  logic [31:0]      status_ptr_i,
   output logic             status_ok_o,
`endif
   codma_chain_checker_if.master mem,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [2:0]       err_code_o,
   output logic [CNT_W-1:0] mism_cnt_o,
   output logic [31:0]      first_mism_addr_o,
   output logic [31:0]      bytes_checked_o
);
   localparam int          AW  = $clog2(MEM_DEPTH);
   localparam int          DW  = 8 * MEM_WIDTH;
   localparam logic [32:0] S   = 33'(MEM_DEPTH * MEM_WIDTH);
   localparam logic [31:0] MW  = 32'(MEM_WIDTH);
   localparam logic [31:0] BG  = 32'(4 * MEM_WIDTH);

   typedef enum logic [3:0] {
      IDLE, DESC0, DESC1, VALIDATE, CMP_REQ, CMP_CHK, LINK,
`ifdef CODMA_CHK_STATUS_EN
      STATUS,
`endif
      DONE
   } state_t;

`ifdef CODMA_CHK_STATUS_EN
   localparam state_t FIN = STATUS;
`else
   localparam state_t FIN = DONE;
`endif

   state_t      state, nxt;
   logic [31:0] ptr, link_cnt, typ, src, dst, len, k;
   logic        done_flag;

   // word1 of the descriptor is still on the ref data bus while validating
   logic [31:0] v_len, v_dst;
   logic [2:0]  v_err;
   logic        last_word, data_eq;
   logic [31:0] nwords;
   assign v_len     = mem.ref_rd_data_i[63:32];
   assign v_dst     = mem.ref_rd_data_i[31:0];
   assign nwords    = len / MW;
   assign last_word = (k + 32'd1 == nwords);
   assign data_eq   = (mem.ref_rd_data_i == mem.dut_rd_data_i);

   // descriptor checks, first failing rule wins
   always_comb begin
      v_err = 3'd0;
      if (typ > 32'd2)
         v_err = 3'd3;
      else if (({1'b0, src} + {1'b0, v_len} > S) || ({1'b0, v_dst} + {1'b0, v_len} > S))
         v_err = 3'd1;
      else if (((typ == 32'd0) ? (v_len % MW) : (v_len % BG)) != 32'd0 ||
               (src % MW) != 32'd0 || (v_dst % MW) != 32'd0)
         v_err = 3'd2;
   end

   // read strobes and word addresses derived from the current state
   always_comb begin
      mem.ref_rd_en_o   = 1'b0;
      mem.ref_rd_addr_o = '0;
      mem.dut_rd_en_o   = 1'b0;
      mem.dut_rd_addr_o = '0;
      case (state)
         DESC0: begin
            mem.ref_rd_en_o   = 1'b1;
            mem.ref_rd_addr_o = AW'(ptr / MW);
         end
         DESC1: begin
            mem.ref_rd_en_o   = 1'b1;
            mem.ref_rd_addr_o = AW'(ptr / MW + 32'd1);
         end
         CMP_REQ: begin
            mem.ref_rd_en_o   = 1'b1;
            mem.ref_rd_addr_o = AW'(src / MW + k);
            mem.dut_rd_en_o   = 1'b1;
            mem.dut_rd_addr_o = AW'(dst / MW + k);
         end
`ifdef CODMA_CHK_STATUS_EN
         STATUS: begin
            mem.dut_rd_en_o   = 1'b1;
            mem.dut_rd_addr_o = AW'(status_ptr_i / MW);
         end
`endif
         default: ;
      endcase
   end

   // next-state selection for the chain walk
   always_comb begin
      nxt = state;
      case (state)
         IDLE:     if (start_i) nxt = DESC0;
         DESC0:    nxt = DESC1;
         DESC1:    nxt = VALIDATE;
         VALIDATE: begin
            if (v_err != 3'd0)       nxt = FIN;
            else if (v_len == 32'd0) nxt = (typ == 32'd2) ? LINK : FIN;
            else                     nxt = CMP_REQ;
         end
         CMP_REQ:  nxt = CMP_CHK;
         CMP_CHK:  begin
            if (last_word) nxt = (typ == 32'd2) ? LINK : FIN;
            else           nxt = CMP_REQ;
         end
         LINK:     nxt = (link_cnt == 32'(MAX_LINKS)) ? FIN : DESC0;
`ifdef CODMA_CHK_STATUS_EN
         STATUS:   nxt = DONE;
`endif
         DONE:     nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end

   // state register plus descriptor fields and result accumulators
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         ptr               <= '0;
         link_cnt          <= '0;
         typ               <= '0;
         src               <= '0;
         dst               <= '0;
         len               <= '0;
         k                 <= '0;
         done_flag         <= 1'b0;
         err_code_o        <= '0;
         mism_cnt_o        <= '0;
         first_mism_addr_o <= '0;
         bytes_checked_o   <= '0;
      end else begin
         state <= nxt;
         case (state)
            IDLE: if (start_i) begin
               ptr               <= task_ptr_i;
               link_cnt          <= 32'd1;
               done_flag         <= 1'b0;
               err_code_o        <= '0;
               mism_cnt_o        <= '0;
               first_mism_addr_o <= '0;
               bytes_checked_o   <= '0;
            end
            DESC1: begin
               typ <= mem.ref_rd_data_i[31:0];
               src <= mem.ref_rd_data_i[63:32];
            end
            VALIDATE: begin
               len        <= v_len;
               dst        <= v_dst;
               k          <= '0;
               err_code_o <= v_err;
            end
            CMP_CHK: begin
               if (!data_eq) begin
                  if (mism_cnt_o == '0) first_mism_addr_o <= dst + k * MW;
                  if (mism_cnt_o != {CNT_W{1'b1}}) mism_cnt_o <= mism_cnt_o + 1'b1;
               end
               bytes_checked_o <= bytes_checked_o + MW;
               k               <= k + 32'd1;
            end
            LINK: begin
               if (link_cnt == 32'(MAX_LINKS)) begin
                  err_code_o <= 3'd4;
               end else begin
                  link_cnt <= link_cnt + 32'd1;
                  ptr      <= ptr + BG;
               end
            end
            DONE: done_flag <= 1'b1;
            default: ;
         endcase
      end
   end

`ifdef CODMA_CHK_STATUS_EN
   logic status_now, status_ok_q;
   assign status_now  = (mem.dut_rd_data_i == ((err_code_o == 3'd1) ? DW'(1) : DW'(0)));
   assign status_ok_o = (state == DONE) ? status_now : status_ok_q;

   // hold the status word verdict after the done pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                           status_ok_q <= 1'b0;
      else if (state == IDLE && start_i)   status_ok_q <= 1'b0;
      else if (state == DONE)              status_ok_q <= status_now;
   end

   assign pass_o = (state == DONE || done_flag) && err_code_o == 3'd0 &&
                   mism_cnt_o == '0 && status_ok_o;
`else
   assign pass_o = (state == DONE || done_flag) && err_code_o == 3'd0 && mism_cnt_o == '0;
`endif

   assign done_o = (state == DONE);
   assign busy_o = (state != IDLE) && (state != DONE);
endmodule

// File: tb/tb_codma_chain_checker.sv
// tb/tb_codma_chain_checker.sv - randomized self-checking bench for codma_chain_checker
module tb_codma_chain_checker;
   localparam int MEM_DEPTH = 32;
   localparam int MEM_WIDTH = 8;
   localparam int MAX_LINKS = 2;
   localparam int CNT_W     = 16;
   localparam int S         = MEM_DEPTH * MEM_WIDTH;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start_i = 1'b0;
   logic [31:0]      task_ptr_i = '0;
   logic             busy_o, done_o, pass_o;
   logic [2:0]       err_code_o;
   logic [CNT_W-1:0] mism_cnt_o;
   logic [31:0]      first_mism_addr_o, bytes_checked_o;

   int          checks = 0;
   int          failures = 0;
   logic [63:0] gold [MEM_DEPTH];
   logic [63:0] dmem [MEM_DEPTH];
   int          exp_q[$];
   int          exp_err, exp_mism, pair_cnt, done_cnt;
   longint      exp_first, exp_bytes;

   codma_chain_checker_if #(.MEM_DEPTH(MEM_DEPTH), .MEM_WIDTH(MEM_WIDTH)) bus ();

   codma_chain_checker #(
      .MEM_DEPTH(MEM_DEPTH), .MEM_WIDTH(MEM_WIDTH), .MAX_LINKS(MAX_LINKS), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .start_i(start_i), .task_ptr_i(task_ptr_i),
      .mem(bus),
      .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_code_o(err_code_o),
      .mism_cnt_o(mism_cnt_o), .first_mism_addr_o(first_mism_addr_o),
      .bytes_checked_o(bytes_checked_o)
   );

   always #5 clk = ~clk;

   // memories with one-cycle read latency
   always @(posedge clk) begin
      if (bus.ref_rd_en_o) bus.ref_rd_data_i <= gold[bus.ref_rd_addr_o];
      if (bus.dut_rd_en_o) bus.dut_rd_data_i <= dmem[bus.dut_rd_addr_o];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // reference: walk the chain straight from the descriptor rules
   task automatic model(input logic [31:0] ptr);
      logic [31:0] p, typ, src, len, dst;
      logic [63:0] d0, d1;
      int links, w, g;
      exp_q.delete();
      exp_err = 0; exp_mism = 0; exp_first = 0; exp_bytes = 0;
      p = ptr; links = 1;
      forever begin
         w  = int'(p / MEM_WIDTH) % MEM_DEPTH;
         d0 = gold[w];
         d1 = gold[(w + 1) % MEM_DEPTH];
         typ = d0[31:0]; src = d0[63:32]; len = d1[63:32]; dst = d1[31:0];
         if (typ > 2) begin exp_err = 3; break; end
         if (longint'(src) + longint'(len) > S || longint'(dst) + longint'(len) > S) begin
            exp_err = 1; break;
         end
         g = (typ == 0) ? MEM_WIDTH : 4 * MEM_WIDTH;
         if (len % g != 0 || src % MEM_WIDTH != 0 || dst % MEM_WIDTH != 0) begin
            exp_err = 2; break;
         end
         for (int k = 0; k < int'(len / MEM_WIDTH); k++) begin
            int sw, dw;
            sw = int'(src / MEM_WIDTH) + k;
            dw = int'(dst / MEM_WIDTH) + k;
            exp_q.push_back(sw * MEM_DEPTH + dw);
            if (gold[sw] != dmem[dw]) begin
               if (exp_mism == 0) exp_first = longint'(dst) + k * MEM_WIDTH;
               if (exp_mism < 2 ** CNT_W - 1) exp_mism++;
            end
            exp_bytes += MEM_WIDTH;
         end
         if (typ != 2) break;
         if (links == MAX_LINKS) begin exp_err = 4; break; end
         links++;
         p += 4 * MEM_WIDTH;
      end
   endtask

   // per-cycle compare of read pairs, in-flight outputs and final results
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.dut_rd_en_o) begin
            pair_cnt++;
            chk("pair_ref_strobe", bus.ref_rd_en_o, 1);
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_read actual=%0d required=none",
                        {bus.ref_rd_addr_o, bus.dut_rd_addr_o});
            end else begin
               chk("rd_addr_pair", {bus.ref_rd_addr_o, bus.dut_rd_addr_o}, exp_q.pop_front());
            end
         end
         if (busy_o) begin
            chk("busy_no_done", done_o, 0);
            chk("busy_no_pass", pass_o, 0);
         end
         if (done_o) begin
            done_cnt++;
            chk("done_busy", busy_o, 0);
            chk("err_code", err_code_o, exp_err);
            chk("mism_cnt", mism_cnt_o, exp_mism);
            chk("first_mism", first_mism_addr_o, exp_first);
            chk("bytes_checked", bytes_checked_o, exp_bytes);
            chk("pass", pass_o, (exp_err == 0 && exp_mism == 0));
            chk("reads_left", exp_q.size(), 0);
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_pass"}, pass_o, 0);
      chk({tag, "_err"}, err_code_o, 0);
      chk({tag, "_mism"}, mism_cnt_o, 0);
      chk({tag, "_first"}, first_mism_addr_o, 0);
      chk({tag, "_bytes"}, bytes_checked_o, 0);
      chk({tag, "_ref_en"}, bus.ref_rd_en_o, 0);
      chk({tag, "_dut_en"}, bus.dut_rd_en_o, 0);
   endtask

   task automatic run(input logic [31:0] ptr, input int inject_at);
      bit seen;
      model(ptr);
      pair_cnt = 0;
      @(negedge clk);
      task_ptr_i = ptr; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      seen = 0;
      for (int c = 0; c < 3000 && !seen; c++) begin
         if (c == inject_at && busy_o) begin
            start_i = 1'b1; task_ptr_i = $urandom;
         end else begin
            start_i = 1'b0;
         end
         @(negedge clk);
         if (done_o) seen = 1;
      end
      start_i = 1'b0;
      chk("done_seen", seen, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic set_desc(input int w, input logic [31:0] typ, input logic [31:0] src,
                           input logic [31:0] len, input logic [31:0] dst);
      gold[w]     = {src, typ};
      gold[w + 1] = {len, dst};
   endtask

   task automatic fill_gold();
      for (int i = 0; i < MEM_DEPTH; i++) gold[i] = {$urandom, $urandom};
   endtask

   task automatic copy_gold();
      for (int i = 0; i < MEM_DEPTH; i++) dmem[i] = gold[i];
   endtask

   task automatic gen_random(output logic [31:0] ptr);
      logic [31:0] src, dst, len, typ;
      int r, w;
      ptr = 32'(8 * $urandom_range(0, 2));
      fill_gold();
      for (int i = 0; i < 3; i++) begin
         r   = $urandom_range(0, 9);
         typ = (r < 2) ? 32'd0 : (r < 5) ? 32'd1 : (r < 9) ? 32'd2 : 32'($urandom_range(3, 50));
         src = 32'(8 * $urandom_range(0, 31));
         dst = 32'(8 * $urandom_range(0, 31));
         len = 32'(((typ == 0) ? 8 : 32) * $urandom_range(0, 2));
         case ($urandom_range(0, 9))
            0: src = src + 4;
            1: len = len + 8;
            2: dst = dst + 2;
            default: ;
         endcase
         set_desc(int'(ptr / 8) + 4 * i, typ, src, len, dst);
      end
      copy_gold();
      for (int i = 0; i < 3; i++) begin
         w   = int'(ptr / 8) + 4 * i;
         src = gold[w][63:32]; len = gold[w + 1][63:32]; dst = gold[w + 1][31:0];
         for (int k = 0; k < int'(len / 8); k++)
            if (int'(src / 8) + k < MEM_DEPTH && int'(dst / 8) + k < MEM_DEPTH)
               dmem[int'(dst / 8) + k] = gold[int'(src / 8) + k];
      end
      for (int j = 0; j < MEM_DEPTH; j++)
         if ($urandom_range(0, 15) == 0) dmem[j] = dmem[j] ^ 64'h1;
   endtask

   initial begin
      logic [31:0] rptr;
      bit          hit;
      done_cnt = 0; pair_cnt = 0;
      fill_gold(); copy_gold();
      repeat (3) @(negedge clk);
      check_zero("rst_held");
      reset = 1'b0;
      @(negedge clk);
      check_zero("rst_idle");

      // single-word copy, all matching
      fill_gold();
      set_desc(0, 0, 64, 16, 128);
      copy_gold();
      dmem[16] = gold[8]; dmem[17] = gold[9];
      run(0, -1);
      chk("t1_model_bytes", exp_bytes, 16);
      chk("t1_pass", pass_o, 1);
      chk("t1_mism", mism_cnt_o, 0);
      chk("t1_bytes", bytes_checked_o, 16);
      chk("t1_pairs", pair_cnt, 2);

      // same, second destination word corrupted
      dmem[17] = ~gold[9];
      run(0, -1);
      chk("t2_model_first", exp_first, 136);
      chk("t2_mism", mism_cnt_o, 1);
      chk("t2_first", first_mism_addr_o, 136);
      chk("t2_pass", pass_o, 0);
      chk("t2_err", err_code_o, 0);

      // source range overflow
      set_desc(0, 1, 240, 32, 0);
      run(0, -1);
      chk("t3_err", err_code_o, 1);
      chk("t3_pairs", pair_cnt, 0);
      chk("t3_pass", pass_o, 0);

      // burst-with-link followed by a single-word task
      fill_gold();
      set_desc(0, 2, 64, 32, 128);
      set_desc(4, 0, 160, 8, 200);
      copy_gold();
      for (int i = 0; i < 4; i++) dmem[16 + i] = gold[8 + i];
      dmem[25] = gold[20];
      run(0, -1);
      chk("t4_pairs", pair_cnt, 5);
      chk("t4_bytes", bytes_checked_o, 40);
      chk("t4_pass", pass_o, 1);

      // chain longer than MAX_LINKS
      fill_gold();
      set_desc(0, 2, 128, 32, 192);
      set_desc(4, 2, 128, 32, 192);
      set_desc(8, 2, 128, 32, 192);
      copy_gold();
      for (int i = 0; i < 4; i++) dmem[24 + i] = gold[16 + i];
      run(0, -1);
      chk("t5_model_err", exp_err, 4);
      chk("t5_err", err_code_o, 4);
      chk("t5_pairs", pair_cnt, 8);
      chk("t5_bytes", bytes_checked_o, 64);

      // reset while a compare is in flight
      fill_gold();
      set_desc(0, 0, 64, 16, 128);
      copy_gold();
      dmem[16] = gold[8]; dmem[17] = gold[9];
      model(0);
      done_cnt = 0;
      @(negedge clk);
      task_ptr_i = 0; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      hit = 0;
      for (int c = 0; c < 50 && !hit; c++) begin
         if (bus.dut_rd_en_o) hit = 1;
         else @(negedge clk);
      end
      chk("t6_reached_cmp", hit, 1);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 check_zero("t6_rst");
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      repeat (4) @(negedge clk);
      chk("t6_no_done", done_cnt, 0);
      run(0, -1);
      chk("t6_fresh_pass", pass_o, 1);

      // randomized chains with a stray start while busy
      for (int t = 0; t < 40; t++) begin
         gen_random(rptr);
         run(rptr, $urandom_range(0, 30));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
